// File: rtl/ring_pkg.sv
// Shared definitions for the Beehive ring-head stage: slot types, resend entry
// layout and FSM state encoding.
package ring_pkg;

  localparam int unsigned SLOT_DATA_W = 32;
  localparam int unsigned SLOT_TYPE_W = 4;
  localparam int unsigned SLOT_SRC_W  = 4;

  localparam logic [SLOT_TYPE_W-1:0] SLOT_TOKEN     = 4'd1;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_ADDRESS   = 4'd2;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_WRITEDATA = 4'd3;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_NULL      = 4'd7;

  // Resend entry bit positions: {dest[39:36], type[35:32], data[31:0]}
  localparam int unsigned RS_DATA_LSB = 0;
  localparam int unsigned RS_TYPE_LSB = 32;
  localparam int unsigned RS_DEST_LSB = 36;
  localparam int unsigned RS_ENTRY_W  = 40;

  localparam int unsigned MA_ENTRY_W  = SLOT_SRC_W + SLOT_DATA_W;

  typedef struct packed {
    logic [SLOT_SRC_W-1:0]  dest;
    logic [SLOT_TYPE_W-1:0] typ;
    logic [SLOT_DATA_W-1:0] data;
  } resend_entry_t;

  typedef struct packed {
    logic [SLOT_SRC_W-1:0]  src;
    logic [SLOT_TYPE_W-1:0] typ;
    logic [SLOT_DATA_W-1:0] data;
  } ring_slot_t;

  typedef struct packed {
    logic [SLOT_SRC_W-1:0]  dest;
    logic [SLOT_DATA_W-1:0] addr;
  } ma_entry_t;

  typedef enum logic {
    DUMP = 1'b0,
    WAIT = 1'b1
  } ring_state_e;

  function automatic ring_slot_t make_slot(input logic [SLOT_TYPE_W-1:0] typ);
    ring_slot_t s;
    s.src  = '0;
    s.typ  = typ;
    s.data = '0;
    return s;
  endfunction

endpackage

// File: rtl/ring_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes when full are dropped and
// flagged on overflow_c, pops when empty are ignored.
module ring_sync_fifo #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LOGSIZE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout_c,
  output logic             empty,
  output logic             full,
  output logic             overflow_c
);

  localparam int unsigned DEPTH = 2 ** LOGSIZE;
  localparam int unsigned CW    = LOGSIZE + 1;

  logic [LOGSIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOGSIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               push_c, pop_c;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  assign push_c = wr && !full_q;
  assign pop_c  = rd && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + LOGSIZE'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + LOGSIZE'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_ptr_q] <= din;
  end

  assign dout_c     = mem_q[rd_ptr_q];
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow_c = wr && full_q;

endmodule

// File: rtl/mem_ring_head.sv
// Ring-head stage: generates tokens, re-injects resend traffic, strips
// consumed slots and captures Address/WriteData slots for the memory side.
module mem_ring_head
  import ring_pkg::*;
#(
  parameter int unsigned RESEND_LOGSIZE = 5,
  parameter int unsigned MA_LOGSIZE     = 9,
  parameter int unsigned MD_LOGSIZE     = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ring_in_data,
  input  logic [3:0]  ring_in_type,
  input  logic [3:0]  ring_in_src,
  output logic [31:0] ring_out_data,
  output logic [3:0]  ring_out_type,
  output logic [3:0]  ring_out_src,
  input  logic        resend_wr,
  input  logic [39:0] resend_din,
  output logic        resend_full,
  output logic        ma_valid,
  output logic [3:0]  ma_dest,
  output logic [31:0] ma_addr,
  input  logic        ma_rd,
  output logic        md_valid,
  output logic [31:0] md_data,
  input  logic        md_rd,
  output logic [2:0]  err_flags
);

  ring_state_e   state_q, state_d;
  ring_slot_t    slot_q, slot_d;
  logic [2:0]    err_q, err_d;

  logic          rs_rd_c, rs_empty, rs_ovf_c;
  logic [RS_ENTRY_W-1:0] rs_dout_c;
  resend_entry_t rs_head_c;

  logic          ma_wr_c, ma_empty, ma_full_unused, ma_ovf_c;
  logic [MA_ENTRY_W-1:0] ma_dout_c;
  ma_entry_t     ma_head_c;

  logic          md_wr_c, md_empty, md_full_unused, md_ovf_c;

  assign ma_wr_c   = (ring_in_type == SLOT_ADDRESS);
  assign md_wr_c   = (ring_in_type == SLOT_WRITEDATA);
  assign rs_head_c = resend_entry_t'(rs_dout_c);
  assign ma_head_c = ma_entry_t'(ma_dout_c);

  ring_sync_fifo #(.WIDTH(RS_ENTRY_W), .LOGSIZE(RESEND_LOGSIZE)) u_resend (
    .clock      (clock),
    .reset      (reset),
    .wr         (resend_wr),
    .din        (resend_din),
    .rd         (rs_rd_c),
    .dout_c     (rs_dout_c),
    .empty      (rs_empty),
    .full       (resend_full),
    .overflow_c (rs_ovf_c)
  );

  ring_sync_fifo #(.WIDTH(MA_ENTRY_W), .LOGSIZE(MA_LOGSIZE)) u_ma (
    .clock      (clock),
    .reset      (reset),
    .wr         (ma_wr_c),
    .din        ({ring_in_src, ring_in_data}),
    .rd         (ma_rd),
    .dout_c     (ma_dout_c),
    .empty      (ma_empty),
    .full       (ma_full_unused),
    .overflow_c (ma_ovf_c)
  );

  ring_sync_fifo #(.WIDTH(SLOT_DATA_W), .LOGSIZE(MD_LOGSIZE)) u_md (
    .clock      (clock),
    .reset      (reset),
    .wr         (md_wr_c),
    .din        (ring_in_data),
    .rd         (md_rd),
    .dout_c     (md_data),
    .empty      (md_empty),
    .full       (md_full_unused),
    .overflow_c (md_ovf_c)
  );

  // Token/resend FSM; ring input is only forwarded while waiting for the token.
  always_comb begin
    state_d = state_q;
    slot_d  = make_slot(SLOT_NULL);
    rs_rd_c = 1'b0;
    case (state_q)
      DUMP: begin
        if (!rs_empty) begin
          rs_rd_c     = 1'b1;
          slot_d.src  = rs_head_c.dest;
          slot_d.typ  = rs_head_c.typ;
          slot_d.data = rs_head_c.data;
        end else begin
          slot_d  = make_slot(SLOT_TOKEN);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ring_in_type == SLOT_TOKEN) begin
          state_d = DUMP;
        end else if (!((ring_in_type == SLOT_ADDRESS) && ring_in_data[31])) begin
          slot_d.src  = ring_in_src;
          slot_d.typ  = ring_in_type;
          slot_d.data = ring_in_data;
        end
      end
      default: state_d = DUMP;
    endcase
    err_d = err_q | {md_ovf_c, ma_ovf_c, rs_ovf_c};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DUMP;
      slot_q  <= make_slot(SLOT_NULL);
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
    end
  end

  assign ring_out_data = slot_q.data;
  assign ring_out_type = slot_q.typ;
  assign ring_out_src  = slot_q.src;
  assign ma_valid      = !ma_empty;
  assign ma_dest       = ma_head_c.dest;
  assign ma_addr       = ma_head_c.addr;
  assign md_valid      = !md_empty;
  assign err_flags     = err_q;

endmodule

// File: tb/tb_mem_ring_head.sv
// Directed bench for mem_ring_head: token flow, resend re-injection, slot
// stripping, MA/MD capture, overflow and reset recovery.
module tb_mem_ring_head;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ring_in_data;
  logic [3:0]  ring_in_type, ring_in_src;
  logic [31:0] ring_out_data;
  logic [3:0]  ring_out_type, ring_out_src;
  logic        resend_wr;
  logic [39:0] resend_din;
  logic        resend_full;
  logic        ma_valid;
  logic [3:0]  ma_dest;
  logic [31:0] ma_addr;
  logic        ma_rd;
  logic        md_valid;
  logic [31:0] md_data;
  logic        md_rd;
  logic [2:0]  err_flags;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mem_ring_head dut (
    .clock         (clock),
    .reset         (reset),
    .ring_in_data  (ring_in_data),
    .ring_in_type  (ring_in_type),
    .ring_in_src   (ring_in_src),
    .ring_out_data (ring_out_data),
    .ring_out_type (ring_out_type),
    .ring_out_src  (ring_out_src),
    .resend_wr     (resend_wr),
    .resend_din    (resend_din),
    .resend_full   (resend_full),
    .ma_valid      (ma_valid),
    .ma_dest       (ma_dest),
    .ma_addr       (ma_addr),
    .ma_rd         (ma_rd),
    .md_valid      (md_valid),
    .md_data       (md_data),
    .md_rd         (md_rd),
    .err_flags     (err_flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    ring_in_type = t;
    ring_in_data = d;
    ring_in_src  = s;
  endtask

  task automatic check_out(input string tag, input logic [3:0] t, input logic [31:0] d,
                           input logic [3:0] s);
    check({tag, ".type"}, 64'(ring_out_type), 64'(t));
    check({tag, ".data"}, 64'(ring_out_data), 64'(d));
    check({tag, ".src"},  64'(ring_out_src),  64'(s));
  endtask

  logic [39:0] rs_vec [3];

  initial begin
    rs_vec[0] = {4'd2, 4'd2, 32'h8000_0040};
    rs_vec[1] = {4'd5, 4'd3, 32'h1234_5678};
    rs_vec[2] = {4'hA, 4'd7, 32'hDEAD_BEEF};

    reset = 1'b1; resend_wr = 1'b0; resend_din = '0; ma_rd = 1'b0; md_rd = 1'b0;
    drive(4'd7, 32'h0, 4'h0);
    step(); step(); step();

    // Reset state
    check_out("rst", 4'd7, 32'h0, 4'h0);
    check("rst.ma_valid", 64'(ma_valid), 64'd0);
    check("rst.md_valid", 64'(md_valid), 64'd0);
    check("rst.resend_full", 64'(resend_full), 64'd0);
    check("rst.err", 64'(err_flags), 64'd0);

    // Release reset: Null still on output, then Token after the first edge
    reset = 1'b0;
    check_out("rel.null", 4'd7, 32'h0, 4'h0);
    step();
    check_out("rel.token", 4'd1, 32'h0, 4'h0);
    drive(4'd7, 32'h0, 4'h6);
    step();
    check_out("wait.fwd_null", 4'd7, 32'h0, 4'h6);

    // Token at input in WAIT: Null, then a fresh Token
    drive(4'd1, 32'h0, 4'h0);
    step();
    check_out("tok.null", 4'd7, 32'h0, 4'h0);
    drive(4'd7, 32'h0, 4'h0);
    step();
    check_out("tok.fresh", 4'd1, 32'h0, 4'h0);

    // Resend re-injection
    for (int i = 0; i < 3; i++) begin
      resend_wr = 1'b1; resend_din = rs_vec[i];
      step();
    end
    resend_wr = 1'b0;
    drive(4'd1, 32'h0, 4'h0);
    step();
    check_out("rs.null", 4'd7, 32'h0, 4'h0);
    drive(4'd7, 32'h0, 4'h0);
    step();
    check_out("rs.e0", 4'd2, 32'h8000_0040, 4'd2);
    step();
    check_out("rs.e1", 4'd3, 32'h1234_5678, 4'd5);
    step();
    check_out("rs.e2", 4'd7, 32'hDEAD_BEEF, 4'hA);
    step();
    check_out("rs.token", 4'd1, 32'h0, 4'h0);

    // Address stripping and capture
    drive(4'd2, 32'h9000_0010, 4'd3);
    step();
    check_out("ma.strip", 4'd7, 32'h0, 4'h0);
    check("ma.valid1", 64'(ma_valid), 64'd1);
    check("ma.head1", 64'({ma_dest, ma_addr}), 64'({4'd3, 32'h9000_0010}));
    drive(4'd2, 32'h1000_0010, 4'd4);
    step();
    check_out("ma.fwd", 4'd2, 32'h1000_0010, 4'd4);
    check("ma.head_kept", 64'({ma_dest, ma_addr}), 64'({4'd3, 32'h9000_0010}));
    drive(4'd7, 32'h0, 4'h0);
    ma_rd = 1'b1;
    step();
    check("ma.head2", 64'({ma_dest, ma_addr}), 64'({4'd4, 32'h1000_0010}));
    step();
    check("ma.drained", 64'(ma_valid), 64'd0);
    step();
    check("ma.pop_empty_err", 64'(err_flags), 64'd0);
    ma_rd = 1'b0;

    // WriteData capture, FWFT order
    for (int i = 0; i < 8; i++) begin
      drive(4'd3, 32'(i), 4'd1);
      step();
      if (i == 0) check("md.valid_first", 64'(md_valid), 64'd1);
    end
    check_out("md.fwd_last", 4'd3, 32'd7, 4'd1);
    drive(4'd7, 32'h0, 4'h0);
    md_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("md.pop%0d.valid", i), 64'(md_valid), 64'd1);
      check($sformatf("md.pop%0d.data", i), 64'(md_data), 64'(i));
      step();
    end
    check("md.drained", 64'(md_valid), 64'd0);
    md_rd = 1'b0;

    // Fill MA to capacity, then one more push overflows
    for (int i = 0; i < 512; i++) begin
      drive(4'd2, 32'(i), 4'd0);
      step();
    end
    check("ma.full_no_err", 64'(err_flags), 64'd0);
    drive(4'd2, 32'hABCD, 4'd9);
    step();
    check("ma.ovf", 64'(err_flags), 64'b010);
    drive(4'd7, 32'h0, 4'h0);
    step(); step();
    check("ma.ovf_sticky", 64'(err_flags), 64'b010);
    check("ma.head_after_ovf", 64'({ma_dest, ma_addr}), 64'({4'd0, 32'd0}));

    // Reset mid-operation flushes everything
    reset = 1'b1;
    step();
    check("rst2.err", 64'(err_flags), 64'd0);
    check("rst2.ma_valid", 64'(ma_valid), 64'd0);
    check_out("rst2.out", 4'd7, 32'h0, 4'h0);

    // Resend push coinciding with the empty check: Token first, entry next phase
    reset = 1'b0;
    resend_wr = 1'b1; resend_din = {4'd6, 4'd2, 32'h0000_0123};
    step();
    resend_wr = 1'b0;
    check_out("race.token", 4'd1, 32'h0, 4'h0);
    drive(4'd1, 32'h0, 4'h0);
    step();
    check_out("race.null", 4'd7, 32'h0, 4'h0);
    drive(4'd7, 32'h0, 4'h0);
    step();
    check_out("race.entry", 4'd2, 32'h0000_0123, 4'd6);
    step();
    check_out("race.token2", 4'd1, 32'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
